mdu_hilo: RTL and testbench

Iterative multiply/divide unit with the architectural HI/LO registers, in the Execute stage directly downstream of the 32x32 register file. It takes the two operand read ports (rs, rt) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It exposes HI/LO for MFHI/MFLO, plus a busy flag the pipeline control uses to stall.

---
 rtl/mdu_hilo_if.sv | 22 ++
 rtl/mdu_hilo.sv | 168 ++++++++++++++++
 tb/tb_mdu_hilo.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_if.sv
// Operand/result bundle between the Execute-stage control and the HI/LO multiply/divide unit.
interface mdu_hilo_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   modport master (
      output start, op, rs_data, rt_data, cancel,
      input  busy, done, hi_out, lo_out
   );

   modport slave (
      input  start, op, rs_data, rt_data, cancel,
      output busy, done, hi_out, lo_out
   );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
module mdu_hilo (
   input logic        clk,
   input logic        rst,
   mdu_hilo_if.slave  bus
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 6;
   localparam int unsigned ITERS = 32;

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN:0]     acc_hi_q, acc_hi_d;
   logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [XLEN-1:0]   a_raw_q, a_raw_d;
   logic              is_div_q, is_div_d;
   logic              neg_q_q, neg_q_d;
   logic              neg_r_q, neg_r_d;
   logic              div0_q, div0_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [XLEN:0]     mul_sum, rem_sh, rem_diff, step_hi;
   logic [XLEN-1:0]   step_lo, a_abs, b_abs, quo, rem;
   logic [2*XLEN-1:0] prod;
   logic              a_neg, b_neg, is_signed;

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         a_raw_q  <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         div0_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         a_raw_q  <= a_raw_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         div0_q   <= div0_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
   always_comb begin
      mul_sum  = {1'b0, acc_hi_q[XLEN-1:0]} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh   = {acc_hi_q[XLEN-1:0], acc_lo_q[XLEN-1]};
      rem_diff = rem_sh - {1'b0, opnd_q};
      if (is_div_q) begin
         step_hi = rem_diff[XLEN] ? rem_sh : rem_diff;
         step_lo = {acc_lo_q[XLEN-2:0], ~rem_diff[XLEN]};
      end else begin
         step_hi = {1'b0, mul_sum[XLEN:1]};
         step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
      end
      prod = {step_hi[XLEN-1:0], step_lo};
      if (neg_q_q) prod = (2*XLEN)'(0) - prod;
      quo = neg_q_q ? XLEN'(0) - step_lo : step_lo;
      rem = neg_r_q ? XLEN'(0) - step_hi[XLEN-1:0] : step_hi[XLEN-1:0];
   end

   // Operand conditioning: signed ops iterate on magnitudes.
   always_comb begin
      is_signed = ~bus.op[0];
      a_neg     = is_signed & bus.rs_data[XLEN-1];
      b_neg     = is_signed & bus.rt_data[XLEN-1];
      a_abs     = a_neg ? XLEN'(0) - bus.rs_data : bus.rs_data;
      b_abs     = b_neg ? XLEN'(0) - bus.rt_data : bus.rt_data;
   end

   // Next-state and output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      a_raw_d  = a_raw_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      div0_d   = div0_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.cancel) begin
               if (!bus.op[2]) begin
                  is_div_d = bus.op[1];
                  opnd_d   = bus.op[1] ? b_abs : a_abs;
                  acc_lo_d = bus.op[1] ? a_abs : b_abs;
                  acc_hi_d = '0;
                  neg_q_d  = a_neg ^ b_neg;
                  neg_r_d  = a_neg;
                  a_raw_d  = bus.rs_data;
                  div0_d   = (bus.rt_data == '0);
                  cnt_d    = CNT_W'(ITERS);
                  busy_d   = 1'b1;
                  state_d  = ST_RUN;
               end else if (bus.op == 3'b100) begin
                  hi_d = bus.rs_data;
               end else if (bus.op == 3'b101) begin
                  lo_d = bus.rs_data;
               end
            end
         end
         ST_RUN: begin
            if (bus.cancel) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               acc_hi_d = step_hi;
               acc_lo_d = step_lo;
               cnt_d    = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  if (!is_div_q) begin
                     hi_d = prod[2*XLEN-1:XLEN];
                     lo_d = prod[XLEN-1:0];
                  end else if (div0_q) begin
                     hi_d = a_raw_q;
                     lo_d = '1;
                  end else begin
                     hi_d = rem;
                     lo_d = quo;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.hi_out = hi_q;
   assign bus.lo_out = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo: arithmetic, MTHI/MTLO, busy-start, cancel and reset.
module tb_mdu_hilo;
   logic clk;
   logic rst;
   int   passed;
   int   total;

   mdu_hilo_if bus ();

   mdu_hilo dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Issue one iterative op and follow it through all 32 iterations.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input string tag, input bit extra);
      int bad;
      bad = 0;
      bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
      tick();
      bus.start = 1'b0;
      bus.rs_data = 32'hA5A5_5A5A;
      bus.rt_data = 32'h0000_0000;
      chk({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
      for (int i = 1; i <= 31; i++) begin
         if (extra && (i == 5 || i == 20)) begin
            bus.start = 1'b1;
            bus.op    = 3'b011;
            bus.rt_data = 32'd1;
         end else begin
            bus.start = 1'b0;
         end
         tick();
         if (!(bus.busy === 1'b1 && bus.done === 1'b0)) bad++;
      end
      bus.start = 1'b0;
      chk({tag, " busy_window_errors"}, 32'(bad), 32'd0);
      tick();
      chk({tag, " busy_end"}, 32'(bus.busy), 32'd0);
      chk({tag, " done_pulse"}, 32'(bus.done), 32'd1);
      chk({tag, " hi"}, bus.hi_out, ehi);
      chk({tag, " lo"}, bus.lo_out, elo);
      tick();
      chk({tag, " done_clear"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int bad;
      passed = 0;
      total  = 0;
      rst = 1'b0;
      bus.start = 1'b0; bus.op = 3'b000; bus.rs_data = '0; bus.rt_data = '0; bus.cancel = 1'b0;
      tick();
      tick();
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset hi", bus.hi_out, 32'd0);
      chk("reset lo", bus.lo_out, 32'd0);
      rst = 1'b1;
      tick();

      run_op(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg", 1'b0);
      run_op(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, "multu", 1'b0);
      run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2", 1'b0);
      run_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_neg2", 1'b0);
      run_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7", 1'b0);
      run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_neg1", 1'b0);
      run_op(3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by_zero", 1'b0);

      // MTHI then MTLO back to back.
      bus.start = 1'b1; bus.op = 3'b100; bus.rs_data = 32'hDEAD_BEEF;
      tick();
      chk("mthi hi", bus.hi_out, 32'hDEAD_BEEF);
      chk("mthi busy", 32'(bus.busy), 32'd0);
      bus.op = 3'b101; bus.rs_data = 32'h0BAD_F00D;
      tick();
      chk("mtlo lo", bus.lo_out, 32'h0BAD_F00D);
      chk("mtlo hi_kept", bus.hi_out, 32'hDEAD_BEEF);
      chk("mtlo busy", 32'(bus.busy), 32'd0);
      chk("mtlo done", 32'(bus.done), 32'd0);
      bus.start = 1'b0;
      tick();

      run_op(3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006, "mult_busy_starts", 1'b1);

      // Cancel at iteration 10.
      bus.start = 1'b1; bus.op = 3'b000; bus.rs_data = 32'd7; bus.rt_data = 32'd9;
      tick();
      bus.start = 1'b0;
      for (int i = 1; i <= 9; i++) tick();
      chk("cancel pre_busy", 32'(bus.busy), 32'd1);
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      chk("cancel busy", 32'(bus.busy), 32'd0);
      chk("cancel done", 32'(bus.done), 32'd0);
      bad = 0;
      for (int i = 0; i < 35; i++) begin
         tick();
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
      end
      chk("cancel quiet_errors", 32'(bad), 32'd0);
      chk("cancel hi_kept", bus.hi_out, 32'h0000_0000);
      chk("cancel lo_kept", bus.lo_out, 32'h0000_0006);

      // start together with cancel while idle does nothing.
      bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 3'b100; bus.rs_data = 32'h5555_5555;
      tick();
      chk("start_cancel hi", bus.hi_out, 32'h0000_0000);
      bus.op = 3'b000; bus.rt_data = 32'd3;
      tick();
      chk("start_cancel busy", 32'(bus.busy), 32'd0);
      bus.start = 1'b0; bus.cancel = 1'b0;
      tick();
      chk("start_cancel lo", bus.lo_out, 32'h0000_0006);

      // Reset in the middle of a divide.
      bus.start = 1'b1; bus.op = 3'b010; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
      tick();
      bus.start = 1'b0;
      for (int i = 1; i <= 15; i++) tick();
      rst = 1'b0;
      tick();
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst done", 32'(bus.done), 32'd0);
      chk("midrst hi", bus.hi_out, 32'd0);
      chk("midrst lo", bus.lo_out, 32'd0);
      rst = 1'b1;
      tick();
      chk("postrst idle_busy", 32'(bus.busy), 32'd0);

      run_op(3'b001, 32'd3, 32'd5, 32'd0, 32'd15, "multu_3_5", 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
